// File: rtl/dm_ctrl.sv
// Data-memory controller: single-port 16-bit memory with a power-on/on-demand
// clear sequence, 1-cycle read latency and a sticky out-of-range error flag.
module dm_ctrl #(
    parameter int DM_DEPTH = 256,
    parameter int DM_AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps_dm_en,
    input  logic        ps_dm_wrt_en,
    input  logic [15:0] dg_dm_add,
    input  logic [15:0] bc_dt,
    input  logic        ps_dm_clr,
    input  logic        ps_dm_err_clr,
    output logic [15:0] dm_bc_dt,
    output logic        dm_rd_vld,
    output logic        dm_busy,
    output logic        dm_err
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [DM_AW-1:0] clr_cnt, clr_cnt_nxt;
    logic [15:0]      mem [DM_DEPTH];

    logic             in_range;
    logic [DM_AW-1:0] idx;
    logic             acc_rd;
    logic             err_set;
    logic             mem_we;
    logic [DM_AW-1:0] mem_wa;
    logic [15:0]      mem_wd;

    // DM_DEPTH is a power of two, so "below depth" means all upper address bits are zero.
    assign idx      = dg_dm_add[DM_AW-1:0];
    assign in_range = (dg_dm_add[15:DM_AW] == '0);

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        acc_rd      = 1'b0;
        err_set     = 1'b0;
        mem_we      = 1'b0;
        mem_wa      = idx;
        mem_wd      = bc_dt;
        dm_busy     = 1'b0;
        case (state)
            INIT: begin
                dm_busy = 1'b1;
                mem_we  = 1'b1;
                mem_wa  = clr_cnt;
                mem_wd  = '0;
                if (ps_dm_clr) begin
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (ps_dm_clr) begin
                    state_nxt   = INIT;
                    clr_cnt_nxt = '0;
                end else if (ps_dm_en) begin
                    err_set = !in_range;
                    if (ps_dm_wrt_en) begin
                        mem_we = in_range;
                    end else begin
                        acc_rd = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt   = INIT;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_bc_dt  <= '0;
            dm_rd_vld <= 1'b0;
            dm_err    <= 1'b0;
        end else begin
            dm_rd_vld <= acc_rd;
            if (acc_rd) begin
                dm_bc_dt <= in_range ? mem[idx] : '0;
            end
            if (err_set) begin
                dm_err <= 1'b1;
            end else if (ps_dm_err_clr) begin
                dm_err <= 1'b0;
            end
        end
    end

    // Array has no reset; rst_n gates the port so a reset edge cannot land a write.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed scenarios plus random traffic
// compared every cycle against a behavioural memory model.
module tb_dm_ctrl;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk;
    logic        rst_n;
    logic        ps_dm_en;
    logic        ps_dm_wrt_en;
    logic [15:0] dg_dm_add;
    logic [15:0] bc_dt;
    logic        ps_dm_clr;
    logic        ps_dm_err_clr;
    logic [15:0] dm_bc_dt;
    logic        dm_rd_vld;
    logic        dm_busy;
    logic        dm_err;

    dm_ctrl #(.DM_DEPTH(DEPTH), .DM_AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ps_dm_en      (ps_dm_en),
        .ps_dm_wrt_en  (ps_dm_wrt_en),
        .dg_dm_add     (dg_dm_add),
        .bc_dt         (bc_dt),
        .ps_dm_clr     (ps_dm_clr),
        .ps_dm_err_clr (ps_dm_err_clr),
        .dm_bc_dt      (dm_bc_dt),
        .dm_rd_vld     (dm_rd_vld),
        .dm_busy       (dm_busy),
        .dm_err        (dm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: cycles of clearing left, memory contents, expected outputs.
    int          busy_left;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] m_dt;
    logic        m_vld;
    logic        m_err;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int a;
        bit inr;
        bit set;
        set = 1'b0;
        a   = int'(dg_dm_add);
        inr = (a < DEPTH);
        if (busy_left > 0) begin
            m_vld = 1'b0;
            if (ps_dm_clr) begin
                busy_left = DEPTH;
            end else begin
                busy_left--;
                if (busy_left == 0) begin
                    foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
                end
            end
        end else if (ps_dm_clr) begin
            busy_left = DEPTH;
            m_vld     = 1'b0;
        end else if (ps_dm_en) begin
            if (ps_dm_wrt_en) begin
                if (inr) ref_mem[a] = bc_dt;
                else set = 1'b1;
                m_vld = 1'b0;
            end else begin
                m_dt  = inr ? ref_mem[a] : 16'h0000;
                m_vld = 1'b1;
                set   = !inr;
            end
        end else begin
            m_vld = 1'b0;
        end
        if (set) m_err = 1'b1;
        else if (ps_dm_err_clr) m_err = 1'b0;
    endtask

    task automatic compare_outputs(input string tag);
        check_eq({tag, ".busy"}, 16'(dm_busy), 16'(busy_left > 0));
        check_eq({tag, ".rd_vld"}, 16'(dm_rd_vld), 16'(m_vld));
        check_eq({tag, ".err"}, 16'(dm_err), 16'(m_err));
        check_eq({tag, ".bc_dt"}, dm_bc_dt, m_dt);
    endtask

    task automatic idle_inputs();
        ps_dm_en      = 1'b0;
        ps_dm_wrt_en  = 1'b0;
        dg_dm_add     = 16'h0000;
        bc_dt         = 16'h0000;
        ps_dm_clr     = 1'b0;
        ps_dm_err_clr = 1'b0;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs(tag);
    endtask

    task automatic drive(input string tag, input bit en, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input bit clr, input bit eclr);
        ps_dm_en      = en;
        ps_dm_wrt_en  = wr;
        dg_dm_add     = a;
        bc_dt         = d;
        ps_dm_clr     = clr;
        ps_dm_err_clr = eclr;
        cycle(tag);
        idle_inputs();
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        busy_left = DEPTH;
        m_dt      = 16'h0000;
        m_vld     = 1'b0;
        m_err     = 1'b0;
        compare_outputs("reset");
        repeat (hold) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (dm_busy && n < 2 * DEPTH) begin
            cycle(tag);
            n++;
        end
        check_eq({tag, ".init_len"}, 16'(n), 16'(DEPTH));
    endtask

    initial begin
        int r;
        logic [15:0] a;
        idle_inputs();
        rst_n     = 1'b0;
        busy_left = DEPTH;
        m_dt      = 16'h0000;
        m_vld     = 1'b0;
        m_err     = 1'b0;
        foreach (ref_mem[i]) ref_mem[i] = 16'hxxxx;

        apply_reset(3);
        wait_init("init0");
        drive("rd_a5", 1, 0, 16'h00A5, 16'h0000, 0, 0);
        cycle("rd_a5_after");

        drive("wr_10", 1, 1, 16'h0010, 16'h1234, 0, 0);
        drive("rd_10", 1, 0, 16'h0010, 16'h0000, 0, 0);
        check_eq("rd_10.data", dm_bc_dt, 16'h1234);

        drive("rd_100", 1, 0, 16'h0100, 16'h0000, 0, 0);
        check_eq("rd_100.err", 16'(dm_err), 16'h0001);
        drive("wr_200", 1, 1, 16'h0200, 16'hBEEF, 0, 0);
        drive("rd_00_after_oor", 1, 0, 16'h0000, 16'h0000, 0, 0);
        drive("err_clr", 0, 0, 16'h0000, 16'h0000, 0, 1);
        check_eq("err_clr.err", 16'(dm_err), 16'h0000);

        drive("wr_03", 1, 1, 16'h0003, 16'h5555, 0, 0);
        drive("clr_wr_03", 1, 1, 16'h0003, 16'hAAAA, 1, 0);
        wait_init("init_clr");
        drive("rd_03", 1, 0, 16'h0003, 16'h0000, 0, 0);
        check_eq("rd_03.data", dm_bc_dt, 16'h0000);

        drive("clr_again", 0, 0, 16'h0000, 16'h0000, 1, 0);
        repeat (100) cycle("init_mid");
        apply_reset(2);
        wait_init("init_rst");

        drive("oor_eclr", 1, 0, 16'hFFFF, 16'h0000, 0, 1);
        check_eq("oor_eclr.err", 16'(dm_err), 16'h0001);

        drive("wr_44", 1, 1, 16'h0044, 16'h7E57, 0, 0);
        ps_dm_en     = 1'b1;
        ps_dm_wrt_en = 1'b0;
        dg_dm_add    = 16'h0044;
        apply_reset(2);
        check_eq("rst_pending.vld", 16'(dm_rd_vld), 16'h0000);
        wait_init("init_rst2");

        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 999));
            a = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, DEPTH - 1)) : 16'($urandom);
            drive("rand", ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, a,
                  16'($urandom), (r < 4), ($urandom_range(0, 9) == 0));
        end
        repeat (2 * DEPTH) cycle("drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
